// File: rtl/nx_dff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// nx_dff_bank_ctrl
//
// Write-path sequencer and round-robin arbiter for a bank of DEPTH x WIDTH
// load-enabled, synchronously-resettable register words. NREQ requesters share
// the single write path. A bank-clear sequence pulses the per-word sync-reset
// strobes on demand.
//
// Configuration macro:
//   NX_DFF_BANK_CLR_ALL_EN  defined   -> clear strobes every word in one cycle
//                           undefined -> clear walks one word per cycle
//
// Ports:
//   CK_i          clock, rising edge
//   R_i           synchronous active-high reset
//   req_i         per-requester level write request          [NREQ]
//   req_addr_i    packed word addresses, k at [k*AW +: AW]   [NREQ*AW]
//   req_data_i    packed write data, k at [k*WIDTH +: WIDTH] [NREQ*WIDTH]
//   gnt_o         one-hot grant pulse                         [NREQ]
//   err_o         pulse: granted address >= DEPTH
//   clr_start_i   request a bank clear
//   clr_busy_o    clear sequence in progress
//   bank_L_o      per-word load enable, one-hot or zero       [DEPTH]
//   bank_R_o      per-word sync-reset strobe                  [DEPTH]
//   bank_I_o      shared write data to all words              [WIDTH]
// -----------------------------------------------------------------------------
module nx_dff_bank_ctrl #(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  CK_i,
  input  logic                  R_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*AW-1:0]    req_addr_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  err_o,
  input  logic                  clr_start_i,
  output logic                  clr_busy_o,
  output logic [DEPTH-1:0]      bank_L_o,
  output logic [DEPTH-1:0]      bank_R_o,
  output logic [WIDTH-1:0]      bank_I_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Clear index must be able to hold DEPTH itself (the "walk finished" value).
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       state_q,   state_d;
  logic [PW-1:0]    ptr_q,     ptr_d;
  logic [CW-1:0]    clr_idx_q, clr_idx_d;
  logic [NREQ-1:0]  gnt_q,     gnt_d;
  logic             err_q,     err_d;
  logic             busy_q,    busy_d;
  logic [DEPTH-1:0] bank_l_q,  bank_l_d;
  logic [DEPTH-1:0] bank_r_q,  bank_r_d;
  logic [WIDTH-1:0] bank_i_q,  bank_i_d;

  // ---------------------------------------------------------------------------
  // Round-robin winner search. A requester granted last cycle is masked so a
  // level request held through its grant cycle is not granted twice.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]  elig;
  logic             found;
  logic [PW-1:0]    win;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic             win_oor;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    elig  = req_i & ~gnt_q;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && elig[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign win_addr = req_addr_i[int'(win)*AW +: AW];
  assign win_data = req_data_i[int'(win)*WIDTH +: WIDTH];

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << AW)) begin : g_no_oor
      assign win_oor = 1'b0;
    end else begin : g_oor
      assign win_oor = ({1'b0, win_addr} >= CW'(DEPTH));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic arb_en;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_idx_d = clr_idx_q;
    gnt_d     = '0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    bank_l_d  = '0;
    bank_r_d  = '0;
    bank_i_d  = bank_i_q;
    arb_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A clear request wins over any same-cycle write request.
        if (clr_start_i) begin
          state_d   = ST_CLEAR;
          busy_d    = 1'b1;
          clr_idx_d = '0;
        end else begin
          arb_en = 1'b1;
        end
      end

      ST_CLEAR: begin
        if (clr_idx_q == CW'(DEPTH)) begin
          // Walk finished: the exit edge already behaves as IDLE, so a waiting
          // request is granted on the same edge that clr_busy falls.
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          clr_idx_d = '0;
          arb_en    = 1'b1;
        end else begin
`ifdef NX_DFF_BANK_CLR_ALL_EN
          bank_r_d  = '1;
          clr_idx_d = CW'(DEPTH);
`else
          bank_r_d  = DEPTH'(1) << clr_idx_q;
          clr_idx_d = clr_idx_q + CW'(1);
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (arb_en && found) begin
      gnt_d[win] = 1'b1;
      bank_i_d   = win_data;
      err_d      = win_oor;
      bank_l_d   = win_oor ? '0 : (DEPTH'(1) << win_addr);
      ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CK_i) begin
    if (R_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      clr_idx_q <= '0;
      gnt_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      bank_l_q  <= '0;
      bank_r_q  <= '0;
      bank_i_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clr_idx_q <= clr_idx_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      bank_l_q  <= bank_l_d;
      bank_r_q  <= bank_r_d;
      bank_i_q  <= bank_i_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign err_o      = err_q;
  assign clr_busy_o = busy_q;
  assign bank_L_o   = bank_l_q;
  assign bank_R_o   = bank_r_q;
  assign bank_I_o   = bank_i_q;

endmodule

// File: tb/tb_nx_dff_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nx_dff_bank_ctrl
//
// Scoreboard bench for nx_dff_bank_ctrl. Two instances share all inputs: an
// 8-word bank (power-of-two) and a 6-word bank (out-of-range addresses
// possible). The stimulus process drives one cycle at a time and pushes the
// hand-computed output set expected after that edge; the monitor pops and
// compares on the falling edge. Expectations for the clear sequence follow the
// NX_DFF_BANK_CLR_ALL_EN build option.
// -----------------------------------------------------------------------------
module tb_nx_dff_bank_ctrl;

`ifdef NX_DFF_BANK_CLR_ALL_EN
  localparam bit CLR_ALL = 1'b1;
`else
  localparam bit CLR_ALL = 1'b0;
`endif

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic                  CK = 1'b0;
  logic                  R;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  clr_start;

  logic [NREQ-1:0] gnt8, gnt6;
  logic            err8, err6, busy8, busy6;
  logic [7:0]      l8, r8;
  logic [5:0]      l6, r6;
  logic [15:0]     i8, i6;

  logic [AW-1:0]    addr_k [NREQ];
  logic [WIDTH-1:0] data_k [NREQ];
  logic             sel6;

  always #5 CK = ~CK;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*AW +: AW]       = addr_k[k];
      req_data[k*WIDTH +: WIDTH] = data_k[k];
    end
  end

  nx_dff_bank_ctrl #(.NREQ(4), .DEPTH(8), .WIDTH(16)) dut8 (
    .CK_i(CK), .R_i(R), .req_i(req), .req_addr_i(req_addr), .req_data_i(req_data),
    .gnt_o(gnt8), .err_o(err8), .clr_start_i(clr_start), .clr_busy_o(busy8),
    .bank_L_o(l8), .bank_R_o(r8), .bank_I_o(i8)
  );

  nx_dff_bank_ctrl #(.NREQ(4), .DEPTH(6), .WIDTH(16)) dut6 (
    .CK_i(CK), .R_i(R), .req_i(req), .req_addr_i(req_addr), .req_data_i(req_data),
    .gnt_o(gnt6), .err_o(err6), .clr_start_i(clr_start), .clr_busy_o(busy6),
    .bank_L_o(l6), .bank_R_o(r6), .bank_I_o(i6)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic        err;
    logic        busy;
    logic [7:0]  l;
    logic [7:0]  r;
    logic [15:0] d;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  obs_t obs;
  int   n_cmp = 0;
  int   n_bad = 0;

  always_comb begin
    if (sel6) obs = '{gnt6, err6, busy6, {2'b00, l6}, {2'b00, r6}, i6};
    else      obs = '{gnt8, err8, busy8, l8, r8, i8};
  end

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b err=%b busy=%b L=%h R=%h I=%h, want gnt=%b err=%b busy=%b L=%h R=%h I=%h",
               name, got.gnt, got.err, got.busy, got.l, got.r, got.d,
               want.gnt, want.err, want.busy, want.l, want.r, want.d);
    end
  endtask

  // Monitor: every registered output set is compared one half-cycle after the
  // edge that produced it.
  always @(negedge CK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, obs, e.o);
    end
  end

  // One clock cycle: drive inputs, take the edge, record what must follow it.
  task automatic step(input string tag, input logic [3:0] rq, input logic clr,
                      input logic rst, input logic [3:0] eg, input logic ee,
                      input logic eb, input logic [7:0] el, input logic [7:0] er,
                      input logic [15:0] ed);
    exp_t e;
    req       = rq;
    clr_start = clr;
    R         = rst;
    @(posedge CK);
    e.o   = '{eg, ee, eb, el, er, ed};
    e.tag = tag;
    exp_q.push_back(e);
    #1;
  endtask

  // Strobe cycles of a clear, following the cycle where clr_busy rises.
  task automatic clear_walk(input string tag, input logic [3:0] rq, input logic first_clr,
                            input int depth, input logic [15:0] ed);
    if (CLR_ALL) begin
      step(tag, rq, first_clr, 1'b0, 4'b0, 1'b0, 1'b1, 8'h00,
           (depth == 8) ? 8'hFF : 8'h3F, ed);
    end else begin
      for (int i = 0; i < depth; i++) begin
        logic [7:0] one;
        one = 8'h01 << i;
        step(tag, rq, (i == 0) ? first_clr : 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 8'h00, one, ed);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel6 = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      addr_k[k] = AW'(k);
      data_k[k] = 16'hA000 + 16'(k);
    end

    // Reset held two cycles with every request asserted.
    step("reset0", 4'b1111, 1'b0, 1'b1, 4'b0000, 0, 0, 8'h00, 8'h00, 16'h0000);
    step("reset1", 4'b1111, 1'b0, 1'b1, 4'b0000, 0, 0, 8'h00, 8'h00, 16'h0000);

    // Round robin with all four requesters held.
    step("rr_g0",  4'b1111, 1'b0, 1'b0, 4'b0001, 0, 0, 8'h01, 8'h00, 16'hA000);
    step("rr_g1",  4'b1111, 1'b0, 1'b0, 4'b0010, 0, 0, 8'h02, 8'h00, 16'hA001);
    step("rr_g2",  4'b1111, 1'b0, 1'b0, 4'b0100, 0, 0, 8'h04, 8'h00, 16'hA002);
    step("rr_g3",  4'b1111, 1'b0, 1'b0, 4'b1000, 0, 0, 8'h08, 8'h00, 16'hA003);
    step("rr_wrap",4'b1111, 1'b0, 1'b0, 4'b0001, 0, 0, 8'h01, 8'h00, 16'hA000);
    step("rr_idle",4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA000);

    // Single requester held six cycles: granted every other cycle.
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0)
        step("hold_gnt", 4'b0100, 1'b0, 1'b0, 4'b0100, 0, 0, 8'h04, 8'h00, 16'hA002);
      else
        step("hold_gap", 4'b0100, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA002);
    end
    step("hold_idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA002);

    // Clear and request on the same edge; clr_start held one extra cycle is ignored.
    step("col_start", 4'b0010, 1'b1, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h00, 16'hA002);
    clear_walk("col_walk", 4'b0010, 1'b1, 8, 16'hA002);
    step("col_grant", 4'b0010, 1'b0, 1'b0, 4'b0010, 0, 0, 8'h02, 8'h00, 16'hA001);
    step("col_idle",  4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA001);

    // Reset in the middle of a clear, then a fresh clear restarts at word 0.
    step("mid_start", 4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h00, 16'hA001);
    if (CLR_ALL) begin
      step("mid_all", 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1, 8'h00, 8'hFF, 16'hA001);
    end else begin
      step("mid_r01", 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h01, 16'hA001);
      step("mid_r02", 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h02, 16'hA001);
      step("mid_r04", 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h04, 16'hA001);
    end
    step("mid_reset",  4'b0000, 1'b0, 1'b1, 4'b0000, 0, 0, 8'h00, 8'h00, 16'h0000);
    step("mid_quiet",  4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'h0000);
    step("re_start",   4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h00, 16'h0000);
    clear_walk("re_walk", 4'b0000, 1'b0, 8, 16'h0000);
    step("re_done",    4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'h0000);

    // Six-word bank: out-of-range address, last valid word, and clear.
    sel6 = 1'b1;
    step("d6_reset", 4'b0000, 1'b0, 1'b1, 4'b0000, 0, 0, 8'h00, 8'h00, 16'h0000);
    addr_k[3] = 3'd7;
    step("d6_oor",   4'b1000, 1'b0, 1'b0, 4'b1000, 1, 0, 8'h00, 8'h00, 16'hA003);
    step("d6_idle",  4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA003);
    addr_k[1] = 3'd5;
    step("d6_last",  4'b0010, 1'b0, 1'b0, 4'b0010, 0, 0, 8'h20, 8'h00, 16'hA001);
    step("d6_idle2", 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA001);
    step("d6_clr",   4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1, 8'h00, 8'h00, 16'hA001);
    clear_walk("d6_walk", 4'b0000, 1'b0, 6, 16'hA001);
    step("d6_done",  4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 8'h00, 8'h00, 16'hA001);

    // Let the monitor consume the last expectation, then confirm nothing is left.
    @(negedge CK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
